// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-timing derivation,
// used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int half_bit(input int clk_freq, input int baud_rate);
        return clks_per_bit(clk_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_64_if.sv
// Serial input and word-level outputs of the 64-bit UART receiver.
// master: the receiver; slave: whoever drives the line and consumes words.
interface uart_rx_64_if;
    logic        rx_line;
    logic [63:0] data_out;
    logic        data_valid;
    logic        frame_err;
    logic        rx_busy;
    logic [2:0]  byte_count;

    modport master (
        input  rx_line,
        output data_out,
        output data_valid,
        output frame_err,
        output rx_busy,
        output byte_count
    );

    modport slave (
        output rx_line,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  rx_busy,
        input  byte_count
    );
endinterface

// File: rtl/uart_rx.sv
// Single-byte 8N1 receiver: 2-flop synchronizer plus IDLE/START/DATA/STOP FSM,
// producing a byte with a one-cycle byte_valid or stop_err pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 27_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_line,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       stop_err,
    output logic       busy
);
    localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int HALF  = half_bit(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W = $clog2(CPB) + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

    logic             rx_meta_r;
    logic             rx_sync_r;
    rx_state_t        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             byte_valid_r;
    logic             stop_err_r;
    logic             busy_r;

    // Synchronizer for the asynchronous line, preset to the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx_line;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Byte receiver FSM with registered pulse and busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= RX_IDLE;
            cnt_r        <= CNT_ZERO;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'd0;
            byte_valid_r <= 1'b0;
            stop_err_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            byte_valid_r <= 1'b0;
            stop_err_r   <= 1'b0;
            case (state_r)
                RX_IDLE: begin
                    cnt_r     <= CNT_ZERO;
                    bit_idx_r <= 3'd0;
                    if (!rx_sync_r) begin
                        state_r <= RX_START;
                        busy_r  <= 1'b1;
                    end
                end
                RX_START: begin
                    if (cnt_r == CNT_HALF) begin
                        cnt_r <= CNT_ZERO;
                        // A start bit that is gone by mid-bit is a glitch, not an error.
                        if (!rx_sync_r) begin
                            state_r <= RX_DATA;
                        end else begin
                            state_r <= RX_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r              <= CNT_ZERO;
                        shift_r[bit_idx_r] <= rx_sync_r;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= RX_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= CNT_ZERO;
                        state_r <= RX_IDLE;
                        busy_r  <= 1'b0;
                        if (rx_sync_r) begin
                            byte_valid_r <= 1'b1;
                        end else begin
                            stop_err_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r <= RX_IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign rx_byte    = shift_r;
    assign byte_valid = byte_valid_r;
    assign stop_err   = stop_err_r;
    assign busy       = busy_r;

endmodule

// File: rtl/uart_rx_64.sv
// 64-bit word receiver: assembles eight UART bytes (first byte = LSB byte).
// Define UART_RX_TIMEOUT_EN to discard partial words after an inter-byte gap.
module uart_rx_64
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 27_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int TIMEOUT_BITS = 20
) (
    input logic         clk,
    input logic         rst,
    uart_rx_64_if.master bus
);
    logic [7:0]  rx_byte_s;
    logic        byte_valid_s;
    logic        stop_err_s;
    logic        busy_s;
    logic        timeout_s;

    logic [55:0] word_r;
    logic [63:0] data_r;
    logic        data_valid_r;
    logic        frame_err_r;
    logic [2:0]  byte_count_r;

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx_line    (bus.rx_line),
        .rx_byte    (rx_byte_s),
        .byte_valid (byte_valid_s),
        .stop_err   (stop_err_s),
        .busy       (busy_s)
    );

`ifdef UART_RX_TIMEOUT_EN
    localparam int TO_CYCLES = TIMEOUT_BITS * clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int TO_W      = $clog2(TO_CYCLES + 1);

    logic [TO_W-1:0] idle_cnt_r;

    assign timeout_s = (byte_count_r != 3'd0) && !busy_s && !byte_valid_s && !stop_err_s
                       && (idle_cnt_r == TO_W'(TO_CYCLES - 1));

    // Idle-gap timer: runs only while a partial word waits in IDLE.
    always_ff @(posedge clk) begin
        if (rst || busy_s || (byte_count_r == 3'd0) || timeout_s) begin
            idle_cnt_r <= {TO_W{1'b0}};
        end else begin
            idle_cnt_r <= idle_cnt_r + 1'b1;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Word assembly, completion pulse and error/timeout discard.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_r       <= 56'd0;
            data_r       <= 64'd0;
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            byte_count_r <= 3'd0;
        end else begin
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            if (stop_err_s || timeout_s) begin
                frame_err_r  <= 1'b1;
                word_r       <= 56'd0;
                byte_count_r <= 3'd0;
            end else if (byte_valid_s) begin
                if (byte_count_r == 3'd7) begin
                    data_r       <= {rx_byte_s, word_r};
                    data_valid_r <= 1'b1;
                    word_r       <= 56'd0;
                    byte_count_r <= 3'd0;
                end else begin
                    for (int i = 0; i < 7; i++) begin
                        if (byte_count_r == 3'(i)) begin
                            word_r[8*i +: 8] <= rx_byte_s;
                        end
                    end
                    byte_count_r <= byte_count_r + 3'd1;
                end
            end
        end
    end

    assign bus.data_out   = data_r;
    assign bus.data_valid = data_valid_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.rx_busy    = busy_s;
    assign bus.byte_count = byte_count_r;

endmodule
